// File: rtl/snes_carrier_pkg.sv
// Shared modes, default ratios and config checks
// for the SNES colour-carrier generator.
package snes_carrier_pkg;

  typedef enum logic {
    MODE_NTSC = 1'b0,
    MODE_PAL  = 1'b1
  } mode_e;

  localparam int NTSC_INC_D = 1;
  localparam int NTSC_MOD_D = 3;
  localparam int PAL_INC_D  = 1;
  localparam int PAL_MOD_D  = 2;
  // 3Chip: 21.28137 MHz * 5/24 = 4.4336 MHz
  localparam int EXTPAL_INC = 5;
  localparam int EXTPAL_MOD = 12;

  function automatic bit acc_cfg_ok(
    int w,
    int inc_n, int mod_n,
    int inc_p, int mod_p
  );
    int m;
    m = (mod_n > mod_p) ? mod_n : mod_p;
    return (inc_n >= 1) && (inc_n < mod_n) &&
           (inc_p >= 1) && (inc_p < mod_p) &&
           ((2 * m - 1) < (1 << w));
  endfunction

endpackage

// File: rtl/snes_carrier_gen_ch.sv
// One carrier channel: mode sync, fractional
// accumulator, boundary-aligned mode switch, lock.
module snes_carrier_ch
  import snes_carrier_pkg::*;
#(
  parameter int ACC_W        = 8,
  parameter int NTSC_INC     = NTSC_INC_D,
  parameter int NTSC_MOD     = NTSC_MOD_D,
  parameter int PAL_INC      = PAL_INC_D,
  parameter int PAL_MOD      = PAL_MOD_D,
  parameter int LOCK_PERIODS = 4
) (
  input  logic MCLK_i,
  input  logic RST_i,
  input  logic EN_i,
  input  logic PALMODE_i,
  output logic CARRIER_o,
  output logic NPALMODE_o,
  output logic VALID_o,
  output logic MODE_CHG_o
);

  localparam int LW = $clog2(LOCK_PERIODS + 1);

  logic             pal_meta;
  logic             pal_s;
  mode_e            mode_q;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] modv;
  logic [ACC_W-1:0] sum;
  logic [LW-1:0]    lock_q;
  logic [LW-1:0]    lock_nx;
  logic             wrap;
  logic             per_end;
  logic             pending;

  always_comb begin
    inc     = ACC_W'(NTSC_INC);
    modv    = ACC_W'(NTSC_MOD);
    if (mode_q == MODE_PAL) begin
      inc  = ACC_W'(PAL_INC);
      modv = ACC_W'(PAL_MOD);
    end
    sum     = acc + inc;
    wrap    = sum >= modv;
    per_end = wrap & CARRIER_o;
    pending = mode_e'(pal_s) != mode_q;
    lock_nx = (lock_q == LW'(LOCK_PERIODS)) ?
              lock_q : lock_q + LW'(1);
  end

  always_ff @(posedge MCLK_i) begin
    if (RST_i) begin
      pal_meta   <= 1'b0;
      pal_s      <= 1'b0;
      mode_q     <= MODE_NTSC;
      acc        <= '0;
      lock_q     <= '0;
      CARRIER_o  <= 1'b0;
      VALID_o    <= 1'b0;
      MODE_CHG_o <= 1'b0;
    end else begin
      pal_meta   <= PALMODE_i;
      pal_s      <= pal_meta;
      MODE_CHG_o <= 1'b0;
      if (!EN_i) begin
        acc       <= '0;
        lock_q    <= '0;
        CARRIER_o <= 1'b0;
        VALID_o   <= 1'b0;
        if (pending) begin
          mode_q     <= mode_e'(pal_s);
          MODE_CHG_o <= 1'b1;
        end
      end else if (per_end && pending) begin
        // switch only where the carrier falls, so no runt pulse
        acc        <= '0;
        lock_q     <= '0;
        CARRIER_o  <= 1'b0;
        VALID_o    <= 1'b0;
        mode_q     <= mode_e'(pal_s);
        MODE_CHG_o <= 1'b1;
      end else begin
        acc <= wrap ? sum - modv : sum;
        if (wrap) CARRIER_o <= ~CARRIER_o;
        if (per_end) begin
          lock_q  <= lock_nx;
          VALID_o <= lock_nx == LW'(LOCK_PERIODS);
        end
      end
    end
  end

  assign NPALMODE_o = mode_q == MODE_NTSC;

endmodule

// File: rtl/snes_carrier_gen.sv
// Multi-channel colour-carrier generator; one
// independent fractional divider per channel.
module snes_carrier_gen
  import snes_carrier_pkg::*;
#(
  parameter int NCH          = 2,
  parameter int ACC_W        = 8,
  parameter int NTSC_INC     = NTSC_INC_D,
  parameter int NTSC_MOD     = NTSC_MOD_D,
  parameter int PAL_INC      = PAL_INC_D,
  parameter int PAL_MOD      = PAL_MOD_D,
  parameter int LOCK_PERIODS = 4
) (
  input  logic           MCLK_i,
  input  logic           RST_i,
  input  logic [NCH-1:0] EN_i,
  input  logic [NCH-1:0] PALMODE_i,
  output logic [NCH-1:0] CARRIER_o,
  output logic [NCH-1:0] NPALMODE_o,
  output logic [NCH-1:0] VALID_o,
  output logic [NCH-1:0] MODE_CHG_o
);

  if (!acc_cfg_ok(ACC_W, NTSC_INC, NTSC_MOD,
                  PAL_INC, PAL_MOD)) begin : g_bad_cfg
    $error("carrier INC/MOD or ACC_W invalid");
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    snes_carrier_ch #(
      .ACC_W        (ACC_W),
      .NTSC_INC     (NTSC_INC),
      .NTSC_MOD     (NTSC_MOD),
      .PAL_INC      (PAL_INC),
      .PAL_MOD      (PAL_MOD),
      .LOCK_PERIODS (LOCK_PERIODS)
    ) u_ch (
      .MCLK_i     (MCLK_i),
      .RST_i      (RST_i),
      .EN_i       (EN_i[i]),
      .PALMODE_i  (PALMODE_i[i]),
      .CARRIER_o  (CARRIER_o[i]),
      .NPALMODE_o (NPALMODE_o[i]),
      .VALID_o    (VALID_o[i]),
      .MODE_CHG_o (MODE_CHG_o[i])
    );
  end

endmodule

// File: tb/tb_snes_carrier_gen.sv
// Directed scoreboard bench for snes_carrier_gen:
// default NTSC/PAL instance plus a 5/12 PAL instance.
module tb_snes_carrier_gen;

  logic       clk = 1'b0;
  logic       rst, rst2;
  logic [1:0] en, pal;
  logic [1:0] car, npal, val, mchg;
  logic [0:0] en2, pal2, car2, npal2, val2, mchg2;

  always #5 clk = ~clk;

  snes_carrier_gen dut (
    .MCLK_i     (clk),
    .RST_i      (rst),
    .EN_i       (en),
    .PALMODE_i  (pal),
    .CARRIER_o  (car),
    .NPALMODE_o (npal),
    .VALID_o    (val),
    .MODE_CHG_o (mchg)
  );

  snes_carrier_gen #(
    .NCH     (1),
    .PAL_INC (5),
    .PAL_MOD (12)
  ) dut2 (
    .MCLK_i     (clk),
    .RST_i      (rst2),
    .EN_i       (en2),
    .PALMODE_i  (pal2),
    .CARRIER_o  (car2),
    .NPALMODE_o (npal2),
    .VALID_o    (val2),
    .MODE_CHG_o (mchg2)
  );

  typedef struct {
    string      tag;
    int         inst;
    int         ch;
    logic [3:0] e;
    logic [3:0] m;
  } exp_t;

  localparam logic [3:0] ALL = 4'b1111;
  localparam logic [3:0] CAR = 4'b1000;

  exp_t q[$];
  int   nerr = 0;
  int   nchk = 0;

  function automatic logic [3:0] mk(int c, int n, int v, int m);
    return {c[0], n[0], v[0], m[0]};
  endfunction

  function automatic logic [3:0] obs(int inst, int ch);
    if (inst == 0)
      return {car[ch], npal[ch], val[ch], mchg[ch]};
    return {car2[0], npal2[0], val2[0], mchg2[0]};
  endfunction

  task automatic push(string tag, int inst, int ch,
                      logic [3:0] e, logic [3:0] m);
    exp_t x;
    x = '{tag, inst, ch, e, m};
    q.push_back(x);
  endtask

  task automatic tick();
    exp_t       x;
    logic [3:0] o;
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      x = q.pop_front();
      o = obs(x.inst, x.ch) & x.m;
      nchk++;
      assert (o === (x.e & x.m)) else begin
        nerr++;
        $error("FAIL %s ch%0d: observed %b expected %b",
               x.tag, x.ch, o, x.e & x.m);
      end
    end
  endtask

  task automatic chk(string tag, int got, int want);
    nchk++;
    assert (got === want) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, got, want);
    end
  endtask

  function automatic logic [3:0] ntsc_run(int k);
    return mk((k / 3) % 2, 1, k >= 24, 0);
  endfunction

  initial begin
    int j, prev, tog, last, lmin, lmax, len;
    rst  = 1'b1;
    rst2 = 1'b1;
    en   = 2'b00;
    pal  = 2'b00;
    en2  = 1'b0;
    pal2 = 1'b1;

    // reset state
    tick();
    for (int c = 0; c < 2; c++)
      push("reset", 0, c, mk(0, 1, 0, 0), ALL);
    push("reset2", 1, 0, mk(0, 1, 0, 0), ALL);
    tick();

    // NTSC default run: 3 high / 3 low, VALID at 24
    rst = 1'b0;
    en  = 2'b11;
    for (int k = 1; k <= 33; k++) begin
      for (int c = 0; c < 2; c++)
        push("ntsc_run", 0, c, ntsc_run(k), ALL);
      tick();
    end

    // ch0 to PAL during high phase; applied at edge 36
    pal[0] = 1'b1;
    for (int k = 34; k <= 70; k++) begin
      j = k - 36;
      push("ch1_ntsc", 0, 1, ntsc_run(k), ALL);
      if (k < 36)
        push("hold_high", 0, 0, mk(1, 1, 1, 0), ALL);
      else if (k == 36)
        push("mode_apply", 0, 0, mk(0, 0, 0, 1), ALL);
      else
        push("pal_run", 0, 0,
             mk((j / 2) % 2, 0, j >= 16, 0), ALL);
      tick();
      // short PAL glitch on ch1 that reverts before period end
      if (k == 60) pal[1] = 1'b1;
      if (k == 62) pal[1] = 1'b0;
    end

    // drop EN on ch1 only
    en = 2'b01;
    push("ch0_unaff", 0, 0, mk(1, 0, 1, 0), ALL);
    push("ch1_off", 0, 1, mk(0, 1, 0, 0), ALL);
    tick();

    // reset mid-high, PAL requested on both through reset
    rst = 1'b1;
    pal = 2'b11;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++)
        push("mid_reset", 0, c, mk(0, 1, 0, 0), ALL);
      tick();
    end

    // PAL applied while EN low, 3 cycles after release
    rst = 1'b0;
    en  = 2'b00;
    for (int r = 1; r <= 5; r++) begin
      for (int c = 0; c < 2; c++)
        push("en_low_pal", 0, c,
             (r < 3) ? mk(0, 1, 0, 0) :
             (r == 3) ? mk(0, 0, 0, 1) : mk(0, 0, 0, 0),
             ALL);
      tick();
    end
    en = 2'b11;
    for (int k = 1; k <= 17; k++) begin
      for (int c = 0; c < 2; c++)
        push("pal_from_rst", 0, c,
             mk((k / 2) % 2, 0, k >= 16, 0), ALL);
      tick();
    end

    // 5/12 PAL: 5 periods in 24 cycles, phases of 2 or 3
    rst2 = 1'b0;
    for (int r = 1; r <= 4; r++) begin
      push("ext_apply", 1, 0,
           (r < 3) ? mk(0, 1, 0, 0) :
           (r == 3) ? mk(0, 0, 0, 1) : mk(0, 0, 0, 0),
           ALL);
      tick();
    end
    en2  = 1'b1;
    prev = 0;
    tog  = 0;
    last = 0;
    lmin = 99;
    lmax = 0;
    for (int k = 1; k <= 24; k++) begin
      push("ext_car", 1, 0, mk(((5 * k) / 12) % 2, 0, 0, 0), CAR);
      tick();
      chk("ext_acc_lt_mod",
          int'(dut2.g_ch[0].u_ch.acc < 8'd12), 1);
      if (int'(car2[0]) != prev) begin
        tog++;
        if (last > 0) begin
          len  = k - last;
          lmin = (len < lmin) ? len : lmin;
          lmax = (len > lmax) ? len : lmax;
        end
        last = k;
      end
      prev = int'(car2[0]);
    end
    chk("ext_periods_x2", tog, 10);
    chk("ext_phase_min", lmin, 2);
    chk("ext_phase_max", lmax, 3);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
